// File: rtl/updown_counter_sched.sv
`default_nettype none
//============================================================================
// Module      : updown_counter_sched
// Description : Round-robin scheduler sharing one external WIDTH-bit up/down
//               counter between two requesters. A granted job loads its start
//               value, lets the counter run exactly 'steps' cycles in the
//               requested direction, then returns the final count on 'result'
//               together with a one-cycle done pulse. While idle the counter
//               is held by reloading it with its own value.
// Optional    : define UDC_SAT_EN to stop a job at the counter boundary
//               instead of wrapping; adds the 'sat' output.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
// Ports
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-low reset
//   req0/req1      in   job request, held until matching grant
//   dir0/dir1      in   1 = count up, 0 = count down
//   start0/start1  in   [WIDTH]  value loaded before counting
//   steps0/steps1  in   [STEP_W] number of count cycles
//   gnt0/gnt1      out  one-cycle grant pulse
//   done0/done1    out  one-cycle completion pulse, result valid with it
//   result         out  [WIDTH]  final count of the last completed job
//   busy           out  high whenever a job is in progress
//   sat            out  (UDC_SAT_EN only) job stopped at a boundary
//   cnt_load       out  counter load enable
//   cnt_ctrl       out  counter direction, 1 = up
//   cnt_data       out  [WIDTH]  counter load data
//   cnt_count      in   [WIDTH]  counter value
//============================================================================
module updown_counter_sched #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              dir0,
    input  logic              dir1,
    input  logic [WIDTH-1:0]  start0,
    input  logic [WIDTH-1:0]  start1,
    input  logic [STEP_W-1:0] steps0,
    input  logic [STEP_W-1:0] steps1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [WIDTH-1:0]  result,
    output logic              busy,
    output logic              cnt_load,
    output logic              cnt_ctrl,
    output logic [WIDTH-1:0]  cnt_data,
`ifdef UDC_SAT_EN
    output logic              sat,
`endif
    input  logic [WIDTH-1:0]  cnt_count
);

    //------------------------------------------------------------------------
    // State encoding
    //------------------------------------------------------------------------
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_RUN  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [STEP_W-1:0] c_ONE_STEP = STEP_W'(1);

    logic [1:0]        r_state;
    logic [1:0]        w_next;

    // Latched job fields
    logic              r_owner;
    logic              r_dir;
    logic [WIDTH-1:0]  r_start;
    logic [STEP_W-1:0] r_steps;
    logic [STEP_W-1:0] r_remaining;

    logic              r_rr;        // requester favoured on a tie
    logic [WIDTH-1:0]  r_result;
    logic              r_done0;
    logic              r_done1;

    logic              w_any_req;
    logic              w_winner;
    logic              w_sat_hit;   // next RUN step would cross a boundary

    //------------------------------------------------------------------------
    // Arbitration: a lone requester wins outright, a tie goes to r_rr.
    //------------------------------------------------------------------------
    assign w_any_req = req0 | req1;
    assign w_winner  = (req0 & req1) ? r_rr : req1;

`ifdef UDC_SAT_EN
    logic r_sat_flag;
    logic r_sat;

    assign w_sat_hit = (r_state == c_RUN) &&
                       ((r_dir  && (cnt_count == {WIDTH{1'b1}})) ||
                        (!r_dir && (cnt_count == {WIDTH{1'b0}})));
    assign sat = r_sat;
`else
    assign w_sat_hit = 1'b0;
`endif

    //------------------------------------------------------------------------
    // State register
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    //------------------------------------------------------------------------
    // Next-state logic
    //------------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_any_req) begin
                    w_next = c_LOAD;
                end
            end
            c_LOAD: begin
                w_next = (r_steps == '0) ? c_DONE : c_RUN;
            end
            c_RUN: begin
                // Leaving on remaining==1 lets the counter advance on this
                // final RUN edge, giving exactly r_steps advances in total.
                if (w_sat_hit || (r_remaining == c_ONE_STEP)) begin
                    w_next = c_DONE;
                end
            end
            c_DONE: begin
                w_next = c_IDLE;
            end
            default: begin
                w_next = c_IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------------
    // Output decode
    //------------------------------------------------------------------------
    always_comb begin
        cnt_load = 1'b1;
        cnt_ctrl = 1'b0;
        cnt_data = cnt_count;   // hold by reloading the current value
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        case (r_state)
            c_LOAD: begin
                cnt_data = r_start;
                cnt_ctrl = r_dir;
                gnt0     = ~r_owner;
                gnt1     = r_owner;
            end
            c_RUN: begin
                // On a boundary hit the counter is frozen for this edge.
                cnt_load = w_sat_hit;
                cnt_ctrl = r_dir;
            end
            default: begin
            end
        endcase
    end

    assign busy   = (r_state != c_IDLE);
    assign result = r_result;
    assign done0  = r_done0;
    assign done1  = r_done1;

    //------------------------------------------------------------------------
    // Job datapath
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner     <= 1'b0;
            r_dir       <= 1'b0;
            r_start     <= '0;
            r_steps     <= '0;
            r_remaining <= '0;
            r_rr        <= 1'b0;
            r_result    <= '0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_winner;
                        r_dir   <= w_winner ? dir1   : dir0;
                        r_start <= w_winner ? start1 : start0;
                        r_steps <= w_winner ? steps1 : steps0;
                    end
                end
                c_LOAD: begin
                    r_remaining <= r_steps;
                end
                c_RUN: begin
                    r_remaining <= r_remaining - c_ONE_STEP;
                end
                c_DONE: begin
                    r_result <= cnt_count;
                    r_done0  <= ~r_owner;
                    r_done1  <= r_owner;
                    r_rr     <= ~r_owner;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef UDC_SAT_EN
    //------------------------------------------------------------------------
    // Saturation flag: set on a boundary exit, published with done.
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sat_flag <= 1'b0;
            r_sat      <= 1'b0;
        end else begin
            r_sat <= 1'b0;
            case (r_state)
                c_LOAD: begin
                    r_sat_flag <= 1'b0;
                end
                c_RUN: begin
                    if (w_sat_hit) begin
                        r_sat_flag <= 1'b1;
                    end
                end
                c_DONE: begin
                    r_sat <= r_sat_flag;
                end
                default: begin
                end
            endcase
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_updown_counter_sched.sv
`default_nettype none
//============================================================================
// Module      : tb_updown_counter_sched
// Description : Self-checking bench for updown_counter_sched. Models the
//               external counter and predicts each job's result, latency and
//               number of counting cycles from plain arithmetic.
// Revision    : 1.0 - initial release
//============================================================================
module tb_updown_counter_sched;

    localparam int WIDTH  = 4;
    localparam int STEP_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0, req1, dir0, dir1;
    logic [WIDTH-1:0]  start0, start1;
    logic [STEP_W-1:0] steps0, steps1;
    logic              gnt0, gnt1, done0, done1, busy;
    logic [WIDTH-1:0]  result;
    logic              cnt_load, cnt_ctrl;
    logic [WIDTH-1:0]  cnt_data;
    logic [WIDTH-1:0]  cnt = '0;
`ifdef UDC_SAT_EN
    logic              sat;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // External up/down counter driven by the scheduler.
    always @(posedge clk) begin
        if (cnt_load)      cnt <= cnt_data;
        else if (cnt_ctrl) cnt <= cnt + 4'd1;
        else               cnt <= cnt - 4'd1;
    end

    updown_counter_sched #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .dir0      (dir0),
        .dir1      (dir1),
        .start0    (start0),
        .start1    (start1),
        .steps0    (steps0),
        .steps1    (steps1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .done0     (done0),
        .done1     (done1),
        .result    (result),
        .busy      (busy),
        .cnt_load  (cnt_load),
        .cnt_ctrl  (cnt_ctrl),
        .cnt_data  (cnt_data),
`ifdef UDC_SAT_EN
        .sat       (sat),
`endif
        .cnt_count (cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: final value, cycles from sampling edge to done, number of
    // counter advances, and whether the job stopped at a boundary.
    function automatic void ref_job(input bit d, input int st, input int sp,
                                    output int res, output int lat,
                                    output int adv, output bit s);
        int v;
        v   = st;
        adv = 0;
        s   = 1'b0;
        for (int i = 0; i < sp; i++) begin
`ifdef UDC_SAT_EN
            if ((d && v == 15) || (!d && v == 0)) begin
                s = 1'b1;
                break;
            end
`endif
            v = d ? (v + 1) % 16 : (v + 15) % 16;
            adv++;
        end
        res = v;
        lat = 3 + (s ? adv + 1 : sp);
    endfunction

    // Issue one job and follow it to completion. Entered and left #1 after
    // a rising edge.
    task automatic run_job(input int who, input bit d, input int st, input int sp);
        int  res, lat, adv, done_at, gnt_at, ngnt, nload0, stray;
        bit  s, seen;
        ref_job(d, st, sp, res, lat, adv, s);
        if (who == 0) begin
            req0 = 1'b1; dir0 = d; start0 = 4'(st); steps0 = 4'(sp);
        end else begin
            req1 = 1'b1; dir1 = d; start1 = 4'(st); steps1 = 4'(sp);
        end
        seen = 0; done_at = 0; gnt_at = 0; ngnt = 0; nload0 = 0; stray = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                // Changes after the grant must not affect the job.
                req0 = 1'b0; req1 = 1'b0;
                start0 = 4'($urandom); start1 = 4'($urandom);
                steps0 = 4'($urandom); steps1 = 4'($urandom);
                dir0 = 1'($urandom);   dir1 = 1'($urandom);
            end
            if ((who == 0) ? gnt0 : gnt1) begin ngnt++; gnt_at = k; end
            if ((who == 0) ? (gnt1 | done1) : (gnt0 | done0)) stray++;
            if (!cnt_load) nload0++;
            if ((who == 0) ? done0 : done1) begin
                seen = 1; done_at = k;
                check("job_result", result, res);
`ifdef UDC_SAT_EN
                check("job_sat", sat, s);
`endif
            end
        end
        check("job_done_seen", seen, 1);
        check("job_gnt_cycle", gnt_at, 1);
        check("job_gnt_count", ngnt, 1);
        check("job_latency", done_at, lat);
        check("job_count_cycles", nload0, adv);
        check("job_other_side_quiet", stray, 0);
        check("job_busy_at_done", busy, 0);
        check("job_counter_final", cnt, res);
        @(posedge clk); #1;
        check("job_done_pulse_len", done0 | done1, 0);
        check("job_counter_hold", cnt, res);
    endtask

    initial begin
        int res0, res1, lat0, lat1, a, bad;
        bit s;
        int gq[$];
        int gt[$];
        int dq[$];
        int dt[$];
        int rq[$];

        rst = 1'b0;
        req0 = 1'b0; req1 = 1'b0; dir0 = 1'b0; dir1 = 1'b0;
        start0 = '0; start1 = '0; steps0 = '0; steps1 = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_gnt", {gnt0, gnt1}, 0);
        check("rst_done", {done0, done1}, 0);
        check("rst_result", result, 0);
        check("rst_cnt_load", cnt_load, 1);
        check("rst_cnt_ctrl", cnt_ctrl, 0);
        check("rst_cnt_data", cnt_data, cnt);
        rst = 1'b1;
        @(posedge clk); #1;

        // Single job: 6 up by 5
        run_job(0, 1'b1, 6, 5);
        // Wrap (or saturate): 2 down by 5
        run_job(1, 1'b0, 2, 5);
        // Zero steps
        run_job(0, 1'b1, 9, 0);
        // Job ending at 5, then idle hold
        run_job(0, 1'b1, 0, 5);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (cnt !== 4'd5 || cnt_load !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("idle_hold_bad_cycles", bad, 0);

        // Reset mid-RUN (rr currently favours requester 1)
        req0 = 1'b1; dir0 = 1'b1; start0 = 4'd3; steps0 = 4'd8;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (k == 1) req0 = 1'b0;
        end
        check("midrun_busy_before", busy, 1);
        #2 rst = 1'b0;
        #1;
        check("midrun_busy", busy, 0);
        check("midrun_cnt_load", cnt_load, 1);
        check("midrun_result", result, 0);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (done0 !== 1'b0 || done1 !== 1'b0 || cnt_load !== 1'b1) bad++;
        end
        rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done0 !== 1'b0 || done1 !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("midrun_no_done", bad, 0);

        // Contention with both requests held: expect 0, 1, 0
        ref_job(1'b1, 1, 2, res0, lat0, a, s);
        ref_job(1'b0, 4, 3, res1, lat1, a, s);
        req0 = 1'b1; dir0 = 1'b1; start0 = 4'd1; steps0 = 4'd2;
        req1 = 1'b1; dir1 = 1'b0; start1 = 4'd4; steps1 = 4'd3;
        for (int k = 1; k <= 80 && dq.size() < 3; k++) begin
            @(posedge clk); #1;
            if (gnt0) begin gq.push_back(0); gt.push_back(k); end
            if (gnt1) begin gq.push_back(1); gt.push_back(k); end
            if (done0) begin dq.push_back(0); dt.push_back(k); rq.push_back(int'(result)); end
            if (done1) begin dq.push_back(1); dt.push_back(k); rq.push_back(int'(result)); end
            if (gq.size() >= 3) begin req0 = 1'b0; req1 = 1'b0; end
        end
        check("cont_gnt_count", gq.size(), 3);
        check("cont_done_count", dq.size(), 3);
        if (gq.size() == 3 && dq.size() == 3) begin
            check("cont_gnt_order", {gq[0][1:0], gq[1][1:0], gq[2][1:0]}, 6'b00_01_00);
            check("cont_done_order", {dq[0][1:0], dq[1][1:0], dq[2][1:0]}, 6'b00_01_00);
            check("cont_result0", rq[0], res0);
            check("cont_result1", rq[1], res1);
            check("cont_result2", rq[2], res0);
            check("cont_gnt0_time", gt[0], 1);
            check("cont_done0_time", dt[0], gt[0] + lat0 - 1);
            check("cont_gnt1_time", gt[1], dt[0] + 1);
            check("cont_done1_time", dt[1], gt[1] + lat1 - 1);
            check("cont_gnt2_time", gt[2], dt[1] + 1);
            check("cont_done2_time", dt[2], gt[2] + lat0 - 1);
        end
        @(posedge clk); #1;

        // Randomized jobs
        for (int j = 0; j < 14; j++) begin
            run_job(int'($urandom_range(0, 1)), 1'($urandom),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            if (j % 2 == 1) begin @(posedge clk); #1; end
            else #0;
            // realign to #1 after a rising edge
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
